// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM states, default width,
// and the iteration-counter width helper.
package mult_pkg;

  localparam int unsigned MULT_WIDTH_DEF = 32;
  localparam int unsigned MULT_CNT_W     = $clog2(MULT_WIDTH_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } mult_state_e;

  function automatic int unsigned mult_cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mult_cla_add.sv
// WIDTH-bit carry-lookahead adder made of 4-bit lookahead cells, rippling carry between cells.
module mult_cla_add
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NCELL = WIDTH / 4;

  logic [NCELL:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_cc;

    assign w_p = a[4*i +: 4] ^ b[4*i +: 4];
    assign w_g = a[4*i +: 4] & b[4*i +: 4];

    // All cell carries derived directly from the cell carry-in.
    assign w_cc[0] = w_c[i];
    assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
    assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);

    assign sum[4*i +: 4] = w_p ^ w_cc[3:0];
    assign w_c[i+1]      = w_cc[4];
  end

  assign cout = w_c[NCELL];

endmodule

// File: rtl/mult_seq.sv
// Sequential radix-2 signed multiplier (sign-magnitude shift-add, one bit per cycle).
// Optional overflow output enabled by defining MULT_OVF_EN.
module mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef MULT_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = mult_cnt_w(WIDTH);

  mult_state_e        r_state;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mb;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_in_fix;
  logic               w_neg;
  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // Most-negative input maps to 2^(WIDTH-1), which is exact as an unsigned value.
  assign w_mag_a = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
  assign w_mag_b = operand_b[WIDTH-1] ? (~operand_b + WIDTH'(1)) : operand_b;

  assign w_in_fix = (r_state == StFix);
  assign w_neg    = r_sign_a ^ r_sign_b;

  // Adder is shared: RUN adds |a| to the upper half, FIX forms ~acc_lo + 1.
  assign w_add_a = w_in_fix ? ~r_acc[WIDTH-1:0] : r_acc[2*WIDTH-1:WIDTH];
  assign w_add_b = (!w_in_fix && r_mb[0]) ? r_mag_a : '0;

  mult_cla_add #(
    .WIDTH(WIDTH)
  ) u_add (
    .a   (w_add_a),
    .b   (w_add_b),
    .cin (w_in_fix),
    .sum (w_sum),
    .cout(w_cout)
  );

`ifdef MULT_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Negative results may reach magnitude 2^(WIDTH-1); positive ones only 2^(WIDTH-1)-1.
  assign w_ovf = w_neg ? ((|r_acc[2*WIDTH-1:WIDTH]) || (r_acc[WIDTH-1] && (|r_acc[WIDTH-2:0])))
                       : (|r_acc[2*WIDTH-1:WIDTH-1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_in_fix) begin
      r_ovf <= w_ovf;
    end
  end

  assign overflow = r_ovf;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_mag_a  <= '0;
      r_mb     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mag_a  <= w_mag_a;
            r_mb     <= w_mag_b;
            r_sign_a <= operand_a[WIDTH-1];
            r_sign_b <= operand_b[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= StRun;
          end
        end
        StRun: begin
          r_acc <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
          r_mb  <= r_mb >> 1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_cnt   <= '0;
            r_state <= StFix;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StFix: begin
          r_result <= w_neg ? w_sum : r_acc[WIDTH-1:0];
          r_done   <= 1'b1;
          r_state  <= StDone;
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases plus random operands
// checked against a 64-bit arithmetic reference.
module tb_mult_seq;

  localparam int unsigned W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] prev_result;

  mult_seq #(
    .WIDTH(W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy     (busy),
    .done     (done),
    .result   (result)
`ifdef MULT_OVF_EN
    ,
    .overflow (ovf)
`endif
  );

`ifndef MULT_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One multiply; optional second start at extra_cyc, reset at rst_cyc, start during DONE.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int extra_cyc,
                         input int rst_cyc, input bit start_in_done);
    logic signed [63:0] sa, sb, p;
    logic [W-1:0] exp_r;
    logic         exp_o;
    int           cyc;
    bit           seen;
    sa    = $signed(a);
    sb    = $signed(b);
    p     = sa * sb;
    exp_r = p[W-1:0];
    exp_o = !((&p[63:W-1]) || (~|p[63:W-1]));

    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    @(negedge clock);
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 3 * W) begin
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        #1 reset = 1'b0;
        prev_result = '0;
        return;
      end
      if (cyc == extra_cyc) begin
        start     = 1'b1;
        operand_a = 32'd100;
        operand_b = 32'd100;
      end else begin
        start = 1'b0;
      end
      check("busy_run", busy, 1);
      check("done_timing", done, (cyc == W + 2));
      if (cyc < W + 2) check("result_hold", result, prev_result);
      if (done) begin
        seen = 1'b1;
        check("latency", cyc, W + 2);
        check("result", result, exp_r);
`ifdef MULT_OVF_EN
        check("overflow", ovf, exp_o);
`endif
      end else begin
        @(negedge clock);
        cyc++;
      end
    end
    check("done_seen", seen, 1);
    prev_result = exp_r;
    if (start_in_done) begin
      start     = 1'b1;
      operand_a = 32'd9;
      operand_b = 32'd9;
    end
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("busy_after", busy, 0);
      check("done_once", done, 0);
      check("result_after", result, exp_r);
      @(negedge clock);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    prev_result = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_ovf", ovf, 0);
    reset = 1'b0;

    do_mult(32'd3, 32'd5, 0, 0, 1'b0);
    do_mult(32'hFFFF_FFF9, 32'd6, 0, 0, 1'b0);
    do_mult(32'h7FFF_FFFF, 32'd2, 0, 0, 1'b0);
    do_mult(32'h8000_0000, 32'd1, 0, 0, 1'b0);
    do_mult(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    do_mult(32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    do_mult(32'd0, 32'h8000_0000, 0, 0, 1'b0);
    do_mult(32'h0001_0000, 32'hFFFF_8000, 0, 0, 1'b0);
    do_mult(32'h0001_0000, 32'h0000_8000, 0, 0, 1'b0);
    do_mult(32'd3, 32'd5, 10, 0, 1'b0);
    do_mult(32'd11, 32'hFFFF_FFFD, 0, 0, 1'b1);
    do_mult(32'd3, 32'd5, 0, 20, 1'b0);
    do_mult(32'd7, 32'd9, 0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_mult($urandom, $urandom, 0, 0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      do_mult(32'($urandom_range(0, 4000)) - 32'd2000, 32'($urandom_range(0, 4000)) - 32'd2000,
              0, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
